note_sequencer: RTL and testbench

NOTE_SEQUENCER -- requirements
Module: note_sequencer

---
 rtl/song_pkg.sv | 15 +
 rtl/dur_counter.sv | 28 ++
 rtl/note_sequencer.sv | 120 ++++++++++++
 tb/tb_note_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/song_pkg.sv
// rtl/song_pkg.sv - shared widths, FSM state type and end-of-song marker
package song_pkg;

  localparam int IDX_W       = 11;
  localparam int DUR_W       = 29;
  localparam int END_OF_SONG = 0;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    PLAY,
    PAUSED
  } state_t;

endpackage

// File: rtl/dur_counter.sv
// rtl/dur_counter.sv - loadable down counter holding the remaining note duration
module dur_counter #(
  parameter int DUR_W = song_pkg::DUR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             enable,
  input  logic [DUR_W-1:0] load_value,
  output logic             zero
);

  logic [DUR_W-1:0] count;

  // load wins over enable; the decrement stops at zero so the count never wraps
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - DUR_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - steps through an external song ROM, one note per duration
module note_sequencer #(
  parameter int IDX_W = song_pkg::IDX_W,
  parameter int DUR_W = song_pkg::DUR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             loop_en,
  input  logic [DUR_W-1:0] note_dur,
  output logic [IDX_W-1:0] note_index,
  output logic             note_valid,
  output logic             note_start,
  output logic             busy,
  output logic             song_done
);

  import song_pkg::*;

  state_t state;
  logic   last_note;   // the note just played sat at the top index; next LOAD ends the song
  logic   end_of_song;
  logic   cnt_load;
  logic   cnt_enable;
  logic   cnt_zero;

  assign end_of_song = (note_dur == DUR_W'(END_OF_SONG)) || last_note;
  assign cnt_load    = (state == LOAD) && !stop && !end_of_song;
  assign cnt_enable  = (state == PLAY);

  dur_counter #(
    .DUR_W (DUR_W)
  ) u_dur_counter (
    .clk        (clk),
    .rst        (rst),
    .load       (cnt_load),
    .enable     (cnt_enable),
    .load_value (note_dur - DUR_W'(1)),
    .zero       (cnt_zero)
  );

  // playback FSM; every output is registered alongside the state it describes
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      note_index <= '0;
      note_valid <= 1'b0;
      note_start <= 1'b0;
      busy       <= 1'b0;
      song_done  <= 1'b0;
      last_note  <= 1'b0;
    end else begin
      note_start <= 1'b0;
      song_done  <= 1'b0;
      if (stop) begin
        state      <= IDLE;
        note_index <= '0;
        note_valid <= 1'b0;
        busy       <= 1'b0;
        last_note  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state      <= LOAD;
              note_index <= '0;
              busy       <= 1'b1;
              last_note  <= 1'b0;
            end
          end
          LOAD: begin
            if (end_of_song) begin
              note_index <= '0;
              last_note  <= 1'b0;
              if (!loop_en) begin
                state     <= IDLE;
                busy      <= 1'b0;
                song_done <= 1'b1;
              end
            end else begin
              state      <= PLAY;
              note_valid <= 1'b1;
              note_start <= 1'b1;
            end
          end
          PLAY: begin
            // the current cycle has already sounded, so pause takes effect after it
            if (pause) begin
              state      <= PAUSED;
              note_valid <= 1'b0;
            end else if (cnt_zero) begin
              state      <= LOAD;
              note_valid <= 1'b0;
              if (note_index == {IDX_W{1'b1}}) begin
                last_note <= 1'b1;
              end else begin
                note_index <= note_index + IDX_W'(1);
              end
            end
          end
          PAUSED: begin
            if (!pause) begin
              state      <= PLAY;
              note_valid <= 1'b1;
            end
          end
          default: begin
            state      <= IDLE;
            note_index <= '0;
            note_valid <= 1'b0;
            busy       <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - scoreboard bench for note_sequencer
module tb_note_sequencer;

  localparam int IDX_W = 11;
  localparam int DUR_W = 29;
  localparam logic [1:0] K_NOTE = 2'd0;
  localparam logic [1:0] K_DONE = 2'd1;

  typedef struct packed {
    logic [1:0]  kind;
    logic [10:0] idx;
    logic [15:0] len;
    logic [3:0]  starts;
  } ev_t;

  logic             clk = 1'b0;
  logic             rst, start, stop, pause, loop_en;
  logic [DUR_W-1:0] note_dur;
  logic [IDX_W-1:0] note_index;
  logic             note_valid, note_start, busy, song_done;

  logic [DUR_W-1:0] rom [2048];
  assign note_dur = rom[note_index];

  note_sequencer #(.IDX_W(IDX_W), .DUR_W(DUR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .pause      (pause),
    .loop_en    (loop_en),
    .note_dur   (note_dur),
    .note_index (note_index),
    .note_valid (note_valid),
    .note_start (note_start),
    .busy       (busy),
    .song_done  (song_done)
  );

  always #5 clk = ~clk;

  int  checks = 0;
  int  passes = 0;
  ev_t exp_q[$];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic push_note(input int idx, input int len, input int starts);
    ev_t e;
    e.kind = K_NOTE; e.idx = 11'(idx); e.len = 16'(len); e.starts = 4'(starts);
    exp_q.push_back(e);
  endtask

  task automatic push_done();
    ev_t e;
    e = '0;
    e.kind = K_DONE;
    exp_q.push_back(e);
  endtask

  task automatic emit(input ev_t got);
    ev_t want;
    checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL unexpected_event: got kind=%0d idx=%0d len=%0d starts=%0d, expected none",
               got.kind, got.idx, got.len, got.starts);
    end else begin
      want = exp_q.pop_front();
      if (got === want) passes++;
      else $display("FAIL event: got kind=%0d idx=%0d len=%0d starts=%0d, expected kind=%0d idx=%0d len=%0d starts=%0d",
                    got.kind, got.idx, got.len, got.starts, want.kind, want.idx, want.len, want.starts);
    end
  endtask

  // monitor: turns note_valid runs and song_done pulses into events
  int         run_len = 0;
  int         run_starts = 0;
  int         since_valid = 0;
  logic [10:0] run_idx = '0;

  always @(negedge clk) begin
    ev_t e;
    if (rst) begin
      run_len = 0; run_starts = 0; since_valid = 0;
    end else begin
      if (note_start) check("start_inside_note", 32'(note_valid), 32'd1);
      if (note_valid) begin
        if (run_len == 0) run_idx = note_index;
        run_len++;
        if (note_start) run_starts++;
        since_valid = 0;
      end else begin
        if (run_len != 0) begin
          e.kind = K_NOTE; e.idx = run_idx; e.len = 16'(run_len); e.starts = 4'(run_starts);
          emit(e);
          run_len = 0; run_starts = 0;
        end
        since_valid++;
      end
      if (song_done) begin
        e = '0; e.kind = K_DONE;
        emit(e);
        check("busy_low_at_done", 32'(busy), 32'd0);
        check("done_gap_after_last_valid", 32'(since_valid), 32'd2);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_song();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin tick(); n++; end while (busy && n < budget);
    check("idle_within_budget", 32'(busy), 32'd0);
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    do begin tick(); n++; end while (!note_valid && n < budget);
    check("valid_within_budget", 32'(note_valid), 32'd1);
  endtask

  task automatic wait_drained(input int budget);
    int n = 0;
    do begin tick(); n++; end while (exp_q.size() != 0 && n < budget);
    check("events_within_budget", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_index"}, 32'(note_index), 32'd0);
    check({tag, "_valid"}, 32'(note_valid), 32'd0);
    check({tag, "_start"}, 32'(note_start), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_done"},  32'(song_done), 32'd0);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 2048; i++) rom[i] = '0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; loop_en = 1'b0;
    clear_rom();
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // {3,1,0}, single pass
    rom[0] = 3; rom[1] = 1;
    push_note(0, 3, 1); push_note(1, 1, 1); push_done();
    start_song();
    wait_idle(50);
    tick();

    // same ROM looping twice, then stop while in LOAD
    loop_en = 1'b1;
    push_note(0, 3, 1); push_note(1, 1, 1); push_note(0, 3, 1); push_note(1, 1, 1);
    start_song();
    wait_drained(100);
    stop = 1'b1; tick(); stop = 1'b0;
    check("loop_stop_busy", 32'(busy), 32'd0);
    check("loop_stop_index", 32'(note_index), 32'd0);
    loop_en = 1'b0;
    tick(); tick();

    // {5,0} paused for 4 cycles after two sounding cycles
    clear_rom(); rom[0] = 5;
    push_note(0, 2, 1); push_note(0, 3, 0); push_done();
    start_song();
    wait_valid(10);
    tick();
    pause = 1'b1; repeat (4) tick(); pause = 1'b0;
    wait_idle(50);
    tick();

    // {2,0} with pause landing on the final cycle: that cycle repeats after resume
    clear_rom(); rom[0] = 2;
    push_note(0, 2, 1); push_note(0, 1, 0); push_done();
    start_song();
    wait_valid(10);
    tick();
    pause = 1'b1; repeat (2) tick(); pause = 1'b0;
    wait_idle(50);
    tick();

    // start and stop together in IDLE
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    check("start_stop_busy", 32'(busy), 32'd0);
    tick();
    check("start_stop_busy_later", 32'(busy), 32'd0);

    // stop during LOAD: no note, no song_done
    clear_rom(); rom[0] = 3;
    start_song();
    check("load_busy", 32'(busy), 32'd1);
    stop = 1'b1; tick(); stop = 1'b0;
    check("load_stop_busy", 32'(busy), 32'd0);
    check("load_stop_index", 32'(note_index), 32'd0);
    repeat (5) tick();

    // reset on the 40th cycle of a 100-cycle note, then replay in full
    clear_rom(); rom[0] = 100;
    start_song();
    wait_valid(10);
    repeat (39) tick();
    rst = 1'b1; tick();
    check_all_zero("midnote_reset");
    rst = 1'b0;
    tick();
    push_note(0, 100, 1); push_done();
    start_song();
    wait_idle(200);
    tick();

    // every entry = 1: runs to the top index and ends without wrapping
    for (int i = 0; i < 2048; i++) rom[i] = 1;
    for (int i = 0; i < 2048; i++) push_note(i, 1, 1);
    push_done();
    start_song();
    wait_idle(5000);
    check("full_rom_index_after_done", 32'(note_index), 32'd0);
    repeat (3) tick();

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
